// File: rtl/afe_spi_arbiter.sv
// Round-robin arbiter that serialises one attenuator word onto one of the two AFE SPI lanes.
// A word goes out MSB first. A latch-enable pulse and an idle gap follow it.
// All pin outputs are registered and trail the FSM state by one cycle.
module afe_spi_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  sysClk,
    input  logic                  sysReset_n,
    input  logic                  reqA_valid,
    input  logic                  reqA_chan,
    input  logic [DATA_WIDTH-1:0] reqA_data,
    output logic                  reqA_ready,
    input  logic                  reqB_valid,
    input  logic                  reqB_chan,
    input  logic [DATA_WIDTH-1:0] reqB_data,
    output logic                  reqB_ready,
    output logic                  busy,
    output logic                  lastGrant,
    output logic [1:0]            AFE_SPI_CLK,
    output logic [1:0]            AFE_SPI_SDI,
    output logic [1:0]            AFE_SPI_LE
);

    localparam int unsigned HalfW = $clog2(CLK_DIV) + 1;
    localparam int unsigned BitW  = $clog2(DATA_WIDTH) + 1;
    localparam logic [HalfW-1:0] HalfLast = HalfW'(CLK_DIV - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StShift, StHold, StLatch, StGap} state_e;

    state_e                state_q, state_d;
    logic [HalfW-1:0]      half_q, half_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic                  phase_q, phase_d;   // 0: SCLK-low half, 1: SCLK-high half
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  chan_q, chan_d;
    logic                  last_grant_q, last_grant_d;
    logic [1:0]            clk_q, clk_d;
    logic [1:0]            sdi_q, sdi_d;
    logic [1:0]            le_q, le_d;
    logic                  busy_q, busy_d;
    logic                  win_a, win_b;
    logic                  half_last;
    logic                  sclk, sdi, le;

    // Round-robin choice: on a tie, the requester that did not win last time goes first
    always_comb begin
        win_b = reqB_valid & (~reqA_valid | ~last_grant_q);
        win_a = reqA_valid & ~win_b;
    end

    assign reqA_ready = (state_q == StIdle) & win_a;
    assign reqB_ready = (state_q == StIdle) & win_b;
    assign half_last  = (half_q == HalfLast);

    // Next-state logic for the FSM, the counters and the captured request
    always_comb begin
        state_d      = state_q;
        half_d       = half_q;
        bit_d        = bit_q;
        phase_d      = phase_q;
        shreg_d      = shreg_q;
        chan_d       = chan_q;
        last_grant_d = last_grant_q;
        case (state_q)
            StIdle: begin
                if (win_a | win_b) begin
                    state_d      = StShift;
                    half_d       = '0;
                    bit_d        = '0;
                    phase_d      = 1'b0;
                    chan_d       = win_b ? reqB_chan : reqA_chan;
                    shreg_d      = win_b ? reqB_data : reqA_data;
                    last_grant_d = win_b;
                end
            end
            StShift: begin
                if (half_last) begin
                    half_d  = '0;
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        if (bit_q == BitLast) begin
                            state_d = StHold;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shreg_d = shreg_q << 1;
                        end
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            StHold: begin
                if (half_last) begin
                    half_d  = '0;
                    state_d = StLatch;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            StLatch: begin
                if (half_last) begin
                    half_d  = '0;
                    state_d = StGap;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            StGap: begin
                if (half_last) begin
                    half_d  = '0;
                    state_d = StIdle;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pin values derived from the current state, steered onto the captured lane
    always_comb begin
        sclk   = (state_q == StShift) & phase_q;
        sdi    = (state_q == StShift) & shreg_q[DATA_WIDTH-1];
        le     = (state_q == StLatch);
        clk_d  = chan_q ? {sclk, 1'b0} : {1'b0, sclk};
        sdi_d  = chan_q ? {sdi, 1'b0}  : {1'b0, sdi};
        le_d   = chan_q ? {le, 1'b0}   : {1'b0, le};
        busy_d = (state_q != StIdle);
    end

    // State and output registers; reset abandons any word in flight
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state_q      <= StIdle;
            half_q       <= '0;
            bit_q        <= '0;
            phase_q      <= 1'b0;
            shreg_q      <= '0;
            chan_q       <= 1'b0;
            last_grant_q <= 1'b1;
            clk_q        <= '0;
            sdi_q        <= '0;
            le_q         <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_q       <= half_d;
            bit_q        <= bit_d;
            phase_q      <= phase_d;
            shreg_q      <= shreg_d;
            chan_q       <= chan_d;
            last_grant_q <= last_grant_d;
            clk_q        <= clk_d;
            sdi_q        <= sdi_d;
            le_q         <= le_d;
            busy_q       <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign lastGrant   = last_grant_q;
    assign AFE_SPI_CLK = clk_q;
    assign AFE_SPI_SDI = sdi_q;
    assign AFE_SPI_LE  = le_q;

endmodule

// File: tb/tb_afe_spi_arbiter.sv
// Bench for afe_spi_arbiter. A driver predicts grants from the arbitration rules and queues
// each expected word. A monitor rebuilds words from the lane pins and checks them.
module tb_afe_spi_arbiter;

    localparam int DW = 8;
    localparam int D  = 4;
    localparam int TX = 2 * D * DW + 3 * D;  // cycles from acceptance until ready may rise again

    typedef struct {
        int          acc;
        bit          chan;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          reqA_valid, reqA_chan, reqA_ready;
    logic          reqB_valid, reqB_chan, reqB_ready;
    logic [DW-1:0] reqA_data, reqB_data;
    logic          busy, lastGrant;
    logic [1:0]    spi_clk, spi_sdi, spi_le;

    logic          d1_a_valid, d1_a_chan, d1_a_ready;
    logic [DW-1:0] d1_a_data;
    logic          d1_b_valid, d1_b_chan, d1_b_ready;
    logic [DW-1:0] d1_b_data;
    logic          d1_busy, d1_last;
    logic [1:0]    d1_clk, d1_sdi, d1_le;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   last_acc = -1000;
    bit   mdl_last = 1'b1;
    exp_t sb_q[$];

    afe_spi_arbiter #(.DATA_WIDTH(DW), .CLK_DIV(D)) u_dut (
        .sysClk(clk), .sysReset_n(rst_n),
        .reqA_valid(reqA_valid), .reqA_chan(reqA_chan), .reqA_data(reqA_data),
        .reqA_ready(reqA_ready),
        .reqB_valid(reqB_valid), .reqB_chan(reqB_chan), .reqB_data(reqB_data),
        .reqB_ready(reqB_ready),
        .busy(busy), .lastGrant(lastGrant),
        .AFE_SPI_CLK(spi_clk), .AFE_SPI_SDI(spi_sdi), .AFE_SPI_LE(spi_le)
    );

    afe_spi_arbiter #(.DATA_WIDTH(DW), .CLK_DIV(1)) u_dut_d1 (
        .sysClk(clk), .sysReset_n(rst_n),
        .reqA_valid(d1_a_valid), .reqA_chan(d1_a_chan), .reqA_data(d1_a_data),
        .reqA_ready(d1_a_ready),
        .reqB_valid(d1_b_valid), .reqB_chan(d1_b_chan), .reqB_data(d1_b_data),
        .reqB_ready(d1_b_ready),
        .busy(d1_busy), .lastGrant(d1_last),
        .AFE_SPI_CLK(d1_clk), .AFE_SPI_SDI(d1_sdi), .AFE_SPI_LE(d1_le)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // One cycle of stimulus; the reference decides who should win from the rules alone
    task automatic drive_cycle(input bit va, input bit ca, input logic [DW-1:0] da,
                               input bit vb, input bit cb, input logic [DW-1:0] db,
                               output bit got_a, output bit got_b);
        bit   idle, ea, eb;
        exp_t e;
        @(negedge clk);
        reqA_valid = va; reqA_chan = ca; reqA_data = da;
        reqB_valid = vb; reqB_chan = cb; reqB_data = db;
        #1;
        idle = (cyc >= last_acc + TX);
        eb   = idle && vb && (!va || !mdl_last);
        ea   = idle && va && !eb;
        chk("readyA", reqA_ready, ea);
        chk("readyB", reqB_ready, eb);
        if (ea || eb) begin
            e.acc  = cyc + 1;
            e.chan = eb ? cb : ca;
            e.data = eb ? db : da;
            sb_q.push_back(e);
            last_acc = cyc + 1;
            mdl_last = eb;
        end
        got_a = ea;
        got_b = eb;
    endtask

    task automatic idle_cycles(input int n);
        bit ga, gb;
        for (int i = 0; i < n; i++) drive_cycle(0, 0, '0, 0, 0, '0, ga, gb);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reqA_valid = 1'b0;
        reqB_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pins", {spi_clk, spi_sdi, spi_le}, 6'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_lastGrant", lastGrant, 1'b1);
        sb_q.delete();
        last_acc = -1000;
        mdl_last = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: rebuilds each word from SCLK edges and matches it on the LE pulse
    initial begin : monitor
        logic [1:0]    p_clk, p_le;
        int            nbits;
        int            le_len[2];
        logic [DW-1:0] word;
        exp_t          e;
        bit            busy_exp;
        p_clk = '0; p_le = '0; nbits = 0; word = '0; le_len[0] = 0; le_len[1] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_clk = '0; p_le = '0; nbits = 0; word = '0; le_len[0] = 0; le_len[1] = 0;
            end else begin
                busy_exp = (cyc >= last_acc + 1) && (cyc <= last_acc + TX);
                chk("busy", busy, busy_exp);
                chk("lastGrant", lastGrant, mdl_last);
                chk("lane_exclusive", (spi_clk[0] | spi_sdi[0] | spi_le[0]) &
                                      (spi_clk[1] | spi_sdi[1] | spi_le[1]), 1'b0);
                for (int l = 0; l < 2; l++) begin
                    if (spi_clk[l] && !p_clk[l]) begin
                        if (sb_q.size() == 0) chk("sclk_without_request", sb_q.size(), 1);
                        else begin
                            chk("sclk_lane", l, sb_q[0].chan);
                            chk("sclk_time", cyc, sb_q[0].acc + 2 * D * nbits + D + 1);
                        end
                        word = {word[DW-2:0], spi_sdi[l]};
                        nbits++;
                    end
                    if (spi_le[l] && !p_le[l]) begin
                        if (sb_q.size() == 0) chk("le_without_request", sb_q.size(), 1);
                        else begin
                            e = sb_q.pop_front();
                            chk("le_lane", l, e.chan);
                            chk("word", word, e.data);
                            chk("bit_count", nbits, DW);
                            chk("le_time", cyc, e.acc + 2 * D * DW + D + 1);
                        end
                        nbits = 0;
                        le_len[l] = 0;
                    end
                    if (spi_le[l]) le_len[l]++;
                    if (!spi_le[l] && p_le[l]) chk("le_width", le_len[l], D);
                end
                p_clk = spi_clk;
                p_le  = spi_le;
            end
        end
    end

    initial begin : stim
        bit            pa, pb, ga, gb, ca, cb;
        logic [DW-1:0] da, db;
        int            acc, c;
        rst_n = 1'b0;
        reqA_valid = 0; reqA_chan = 0; reqA_data = '0;
        reqB_valid = 0; reqB_chan = 0; reqB_data = '0;
        d1_a_valid = 0; d1_a_chan = 0; d1_a_data = '0;
        d1_b_valid = 0; d1_b_chan = 0; d1_b_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_pins", {spi_clk, spi_sdi, spi_le}, 6'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_lastGrant", lastGrant, 1'b1);
        chk("reset_ready", {reqA_ready, reqB_ready}, 2'b00);
        #2 rst_n = 1'b1;

        // Simultaneous requests straight after reset: A first, then B
        pa = 1; ca = 0; da = 8'h11; pb = 1; cb = 1; db = 8'h22;
        for (int i = 0; i < 300 && (pa || pb); i++) begin
            drive_cycle(pa, ca, da, pb, cb, db, ga, gb);
            if (ga) pa = 0;
            if (gb) pb = 0;
        end
        idle_cycles(TX + 4);

        // Lone request from A on lane 0
        pa = 1;
        for (int i = 0; i < 10 && pa; i++) begin
            drive_cycle(1, 0, 8'hA5, 0, 0, '0, ga, gb);
            if (ga) pa = 0;
        end
        idle_cycles(TX + 4);

        // Both requesters keep asking: grants must alternate
        pa = 1; pb = 1; ca = 0; cb = 1; da = 8'h3C; db = 8'hC3;
        for (int i = 0; i < 4 * (TX + 1) + 4; i++) begin
            drive_cycle(pa, ca, da, pb, cb, db, ga, gb);
            if (ga) begin ca = 1'($urandom); da = DW'($urandom); end
            if (gb) begin cb = 1'($urandom); db = DW'($urandom); end
        end
        idle_cycles(TX + 4);

        // A raises and withdraws valid during a B transfer: A must never be granted
        pb = 1;
        for (int i = 0; i < 10 && pb; i++) begin
            drive_cycle(0, 0, '0, 1, 0, 8'h5A, ga, gb);
            if (gb) pb = 0;
        end
        for (int i = 0; i < 10; i++) drive_cycle(1, 1, 8'h77, 0, 0, '0, ga, gb);
        idle_cycles(TX + 4);

        // Reset in the middle of a transfer, then a normal transfer afterwards
        pa = 1;
        for (int i = 0; i < 10 && pa; i++) begin
            drive_cycle(1, 1, 8'h96, 0, 0, '0, ga, gb);
            if (ga) pa = 0;
        end
        idle_cycles(29);
        pulse_reset();
        pa = 1;
        for (int i = 0; i < 10 && pa; i++) begin
            drive_cycle(1, 0, 8'h69, 0, 0, '0, ga, gb);
            if (ga) pa = 0;
        end
        idle_cycles(TX + 4);

        // Random traffic: requests come and go, data wobbles while waiting
        pa = 0; pb = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!pa && $urandom_range(0, 9) == 0) begin
                pa = 1; ca = 1'($urandom); da = DW'($urandom);
            end else if (pa && $urandom_range(0, 49) == 0) pa = 0;
            if (pa && $urandom_range(0, 7) == 0) da = DW'($urandom);
            if (!pb && $urandom_range(0, 9) == 0) begin
                pb = 1; cb = 1'($urandom); db = DW'($urandom);
            end else if (pb && $urandom_range(0, 49) == 0) pb = 0;
            if (pb && $urandom_range(0, 7) == 0) db = DW'($urandom);
            drive_cycle(pa, ca, da, pb, cb, db, ga, gb);
            if (ga) pa = 0;
            if (gb) pb = 0;
        end
        idle_cycles(TX + 4);
        chk("scoreboard_drained", sb_q.size(), 0);

        // Fastest divider: 0xFF on lane 1, SCLK toggles every cycle
        @(negedge clk);
        d1_a_valid = 1; d1_a_chan = 1; d1_a_data = 8'hFF;
        #1;
        chk("d1_ready_first", d1_a_ready, 1'b1);
        acc = cyc + 1;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            c = cyc - acc;
            d1_a_valid = (c >= 17 && c <= 19);
            chk("d1_pins", {d1_clk, d1_sdi, d1_le},
                {1'(c >= 1 && c <= 16 && c % 2 == 0), 1'b0,
                 1'(c >= 1 && c <= 16), 1'b0,
                 1'(c == 18), 1'b0});
            chk("d1_busy", d1_busy, 1'(c >= 1 && c <= 19));
            #1;
            chk("d1_ready", d1_a_ready, 1'(c == 19));
        end
        @(negedge clk);
        d1_a_valid = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
